// File: rtl/bidir_pio_param_if.sv
// Avalon-MM slave bus bundle for bidir_pio_param: register select, write strobe,
// write/read data and the level interrupt.
interface bidir_pio_param_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned AW = 3;

  logic [AW-1:0]    address;
  logic             chipselect;
  logic             write_n;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] readdata;
  logic             irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/bidir_pio_param.sv
// Parameterised bidirectional PIO: per-bit direction, synchronised pin sampling,
// edge capture with W1C and a maskable level irq. Macro PIO_OUTSETCLR_EN adds OUTSET/OUTCLR.
module bidir_pio_param #(
  parameter int unsigned      WIDTH       = 4,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_OUT   = '0,
  parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  bidir_pio_param_if.slave   bus,
  inout  wire  [WIDTH-1:0]   bidir_port
);

  localparam int unsigned AW = 3;
  localparam logic [AW-1:0] ADDR_DATA   = AW'(0);
  localparam logic [AW-1:0] ADDR_DIR    = AW'(1);
  localparam logic [AW-1:0] ADDR_MASK   = AW'(2);
  localparam logic [AW-1:0] ADDR_EDGE   = AW'(3);
`ifdef PIO_OUTSETCLR_EN
  localparam logic [AW-1:0] ADDR_OUTSET = AW'(4);
  localparam logic [AW-1:0] ADDR_OUTCLR = AW'(5);
`endif

  logic [WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_readdata;

  logic             w_wr;
  logic [WIDTH-1:0] w_sync_last;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_w1c;
  logic [WIDTH-1:0] w_data_out_nxt;
  logic [WIDTH-1:0] w_rd_mux;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_sync_last = r_sync[SYNC_STAGES-1];

  // Per-pin tristate; undriven pins still feed the synchroniser.
  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    assign bidir_port[g] = r_dir[g] ? r_data_out[g] : 1'bz;
  end

  if (EDGE_TYPE == 0) begin : g_rise
    assign w_edge = w_sync_last & ~r_prev;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign w_edge = ~w_sync_last & r_prev;
  end else begin : g_any
    assign w_edge = w_sync_last ^ r_prev;
  end

  assign w_w1c = (w_wr && (bus.address == ADDR_EDGE)) ? bus.writedata : '0;

  always_comb begin
    w_data_out_nxt = r_data_out;
    if (w_wr) begin
      case (bus.address)
        ADDR_DATA:   w_data_out_nxt = bus.writedata;
`ifdef PIO_OUTSETCLR_EN
        ADDR_OUTSET: w_data_out_nxt = r_data_out | bus.writedata;
        ADDR_OUTCLR: w_data_out_nxt = r_data_out & ~bus.writedata;
`endif
        default:     w_data_out_nxt = r_data_out;
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      ADDR_DATA: w_rd_mux = w_sync_last;
      ADDR_DIR:  w_rd_mux = r_dir;
      ADDR_MASK: w_rd_mux = r_mask;
      ADDR_EDGE: w_rd_mux = r_edge_cap;
      default:   w_rd_mux = '0;
    endcase
  end

  // Control registers and read-data pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RESET_OUT;
      r_dir      <= RESET_DIR;
      r_mask     <= '0;
      r_readdata <= '0;
    end else begin
      r_data_out <= w_data_out_nxt;
      r_readdata <= w_rd_mux;
      if (w_wr && (bus.address == ADDR_DIR))  r_dir  <= bus.writedata;
      if (w_wr && (bus.address == ADDR_MASK)) r_mask <= bus.writedata;
    end
  end

  // Synchroniser chain, edge history and capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev     <= '0;
      r_edge_cap <= '0;
    end else begin
      r_sync[0] <= bidir_port;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev     <= w_sync_last;
      r_edge_cap <= (r_edge_cap & ~w_w1c) | w_edge;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge_cap & r_mask);

endmodule

// File: tb/tb_bidir_pio_param.sv
// Self-checking bench for bidir_pio_param: directed register/pin scenarios plus a
// randomized phase, all compared against a pin-history reference model.
module tb_bidir_pio_param;

  localparam int unsigned      W   = 4;
  localparam int unsigned      S   = 2;
  localparam int unsigned      ET  = 0;
  localparam logic [W-1:0]     ROUT = '0;
  localparam logic [W-1:0]     RDIR = '0;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bidir_pio_param_if #(.WIDTH(W)) bus ();

  wire  [W-1:0] pins;
  logic [W-1:0] tb_oe;
  logic [W-1:0] tb_val;

  for (genvar g = 0; g < W; g++) begin : g_drv
    assign pins[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  bidir_pio_param #(
    .WIDTH(W), .SYNC_STAGES(S), .EDGE_TYPE(ET), .RESET_OUT(ROUT), .RESET_DIR(RDIR)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .bidir_port (pins)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: register contents plus the list of pin values seen at each clk edge.
  logic [W-1:0] m_out, m_dir, m_mask, m_edge, m_rd;
  logic [W-1:0] hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] edge_of(input logic [W-1:0] cur, input logic [W-1:0] old);
    if (ET == 0)      return cur & ~old;
    else if (ET == 1) return ~cur & old;
    else              return cur ^ old;
  endfunction

  function automatic logic m_irq();
    return |(m_edge & m_mask);
  endfunction

  task automatic model_reset();
    m_out  = ROUT;
    m_dir  = RDIR;
    m_mask = '0;
    m_edge = '0;
    m_rd   = '0;
    hist.delete();
    for (int i = 0; i <= int'(S); i++) hist.push_back('0);
  endtask

  // One clock: predict from pre-edge state, let the edge happen, check at the negedge.
  task automatic step();
    logic [W-1:0] pin, seen, seen_old, wd, n_out, n_dir, n_mask, n_edge, n_rd;
    logic [2:0]   a;
    bit           wr;
    pin      = (m_dir & m_out) | (~m_dir & tb_val);
    seen     = hist[hist.size() - S];
    seen_old = hist[hist.size() - S - 1];
    wr       = bus.chipselect && !bus.write_n;
    a        = bus.address;
    wd       = bus.writedata;
    case (a)
      3'd0:    n_rd = seen;
      3'd1:    n_rd = m_dir;
      3'd2:    n_rd = m_mask;
      3'd3:    n_rd = m_edge;
      default: n_rd = '0;
    endcase
    n_edge = (m_edge & ~((wr && a == 3'd3) ? wd : '0)) | edge_of(seen, seen_old);
    n_out  = m_out;
    n_dir  = m_dir;
    n_mask = m_mask;
    if (wr) begin
      if (a == 3'd0) n_out  = wd;
      if (a == 3'd1) n_dir  = wd;
      if (a == 3'd2) n_mask = wd;
`ifdef PIO_OUTSETCLR_EN
      if (a == 3'd4) n_out = m_out | wd;
      if (a == 3'd5) n_out = m_out & ~wd;
`endif
    end
    @(posedge clk);
    m_out  = n_out;
    m_dir  = n_dir;
    m_mask = n_mask;
    m_edge = n_edge;
    m_rd   = n_rd;
    hist.push_back(pin);
    if (hist.size() > 16) void'(hist.pop_front());
    @(negedge clk);
    tb_oe = ~m_dir;
    #1;
    chk("readdata", 32'(bus.readdata), 32'(m_rd));
    chk("irq", 32'(bus.irq), 32'(m_irq()));
    chk("pins_driven", 32'(pins & m_dir), 32'(m_out & m_dir));
  endtask

  task automatic idle(input logic [2:0] a, input int n);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = a;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = a;
    bus.writedata  = d;
    step();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    tb_oe = ~m_dir;
    chk("rst_readdata", 32'(bus.readdata), 32'h0);
    chk("rst_irq", 32'(bus.irq), 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_readdata", 32'(bus.readdata), 32'h0);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    tb_val         = '0;
    tb_oe          = '1;
    @(negedge clk);

    // Reset state, then DIR reads 0.
    apply_reset();
    idle(3'd1, 1);
    chk("dir_after_rst", 32'(bus.readdata), 32'h0);

    // Drive 1010 and read it back through the synchroniser.
    wr(3'd1, 4'hF);
    wr(3'd0, 4'hA);
    chk("pins_1010", 32'(pins), 32'hA);
    idle(3'd0, 3);
    chk("data_readback", 32'(bus.readdata), 32'hA);

    // Rising edge on pin0 with mask 1: irq at the third edge, cleared by W1C.
    wr(3'd1, 4'h0);
    tb_val = 4'h0;
    idle(3'd3, 4);
    wr(3'd3, 4'hF);
    wr(3'd2, 4'h1);
    idle(3'd3, 1);
    tb_val = 4'h1;
    idle(3'd3, 2);
    chk("irq_not_yet", 32'(bus.irq), 32'h0);
    idle(3'd3, 1);
    chk("irq_edge3", 32'(bus.irq), 32'h1);
    wr(3'd3, 4'h1);
    chk("irq_cleared", 32'(bus.irq), 32'h0);

    // Pin1 edge landing on the same cycle as its W1C: the capture wins.
    tb_val = 4'h3;
    idle(3'd3, 2);
    wr(3'd3, 4'h2);
    idle(3'd3, 1);
    chk("set_beats_clear", 32'(bus.readdata & 4'h2), 32'h2);

    // Unmasking a pending bit raises irq one cycle after the write.
    wr(3'd2, 4'h2);
    chk("unmask_irq", 32'(bus.irq), 32'h1);

    // OUTSET/OUTCLR, or no effect when they are not built.
    wr(3'd1, 4'hF);
    wr(3'd0, 4'h5);
    wr(3'd4, 4'h2);
    wr(3'd5, 4'h1);
`ifdef PIO_OUTSETCLR_EN
    chk("outsetclr", 32'(pins), 32'h6);
`else
    chk("outsetclr_off", 32'(pins), 32'h5);
`endif
    idle(3'd4, 1);
    chk("addr4_read0", 32'(bus.readdata), 32'h0);
    idle(3'd5, 1);
    chk("addr5_read0", 32'(bus.readdata), 32'h0);

    // Randomized register traffic and pin activity.
    for (int i = 0; i < 400; i++) begin
      bus.address    = 3'($urandom_range(0, 7));
      bus.chipselect = 1'($urandom);
      bus.write_n    = 1'($urandom);
      bus.writedata  = W'($urandom);
      if ($urandom_range(0, 2) == 0) tb_val = W'($urandom);
      step();
    end

    // Raise irq on every bit, then reset mid-operation.
    wr(3'd1, 4'h0);
    wr(3'd2, 4'hF);
    tb_val = 4'h0;
    idle(3'd3, 4);
    tb_val = 4'hF;
    idle(3'd3, 4);
    chk("irq_pre_reset", 32'(bus.irq), 32'h1);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = 3'd0;
    bus.writedata  = 4'h9;
    apply_reset();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    idle(3'd3, 1);
    chk("edge_after_reset", 32'(bus.readdata), 32'h0);
    idle(3'd1, 1);
    chk("dir_after_reset", 32'(bus.readdata), 32'(RDIR));
    chk("irq_after_reset", 32'(bus.irq), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
